// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// The instruction memory and the PC use the same definitions.
package imem_loader_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port used by the boot loader.
// The loader is the slave side; the host/memory side is the master.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W,
    parameter int DATA_W = imem_loader_pkg::DATA_W
);
    import imem_loader_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed, checksummed byte stream into
// 16-bit words, writes them to instruction memory and releases the CPU on success.
module imem_loader #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W,
    parameter int DATA_W = imem_loader_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);
    import imem_loader_pkg::*;

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LEN  = ST_LEN;
    localparam logic [2:0] S_HI   = ST_HI;
    localparam logic [2:0] S_LO   = ST_LO;
    localparam logic [2:0] S_CSUM = ST_CSUM;
    localparam logic [2:0] S_DONE = ST_DONE;
    localparam logic [2:0] S_ERR  = ST_ERR;

    logic [2:0]        state;
    logic [8:0]        remaining;
    logic [ADDR_W-1:0] index;
    logic [7:0]        sum;
    logic [7:0]        hi_byte;
    logic              accept;

    assign bus.in_ready = (state == S_LEN) || (state == S_HI) ||
                          (state == S_LO)  || (state == S_CSUM);
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            index       <= '0;
            sum         <= '0;
            hi_byte     <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state       <= S_LEN;
                        remaining   <= '0;
                        index       <= '0;
                        sum         <= '0;
                        bus.wr_addr <= '0;
                        cpu_hold    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err         <= 1'b0;
                    end
                end
                S_LEN: begin
                    // A length byte of zero stands for a full 256-word image.
                    if (accept) begin
                        remaining <= {(bus.in_data == 8'd0), bus.in_data};
                        sum       <= bus.in_data;
                        state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= bus.in_data;
                        sum     <= sum + bus.in_data;
                        state   <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= index;
                        bus.wr_data <= DATA_W'({hi_byte, bus.in_data});
                        sum         <= sum + bus.in_data;
                        remaining   <= remaining - 9'd1;
                        // Index is only advanced when another word follows, so it stops at 0xFF.
                        if (remaining == 9'd1) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_HI;
                            index <= index + ADDR_W'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_data == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes
// plus end-of-load status checks.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk;
    logic rst;
    logic start;
    logic cpu_hold;
    logic busy;
    logic done;
    logic err;

    imem_loader_if bus ();

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] sb[$];
    logic [7:0]  stream[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_wr", {24'd0, bus.wr_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] exp;
                exp = sb.pop_front();
                checkOutput("wr_addr", {24'd0, bus.wr_addr}, {24'd0, exp[23:16]});
                checkOutput("wr_data", {16'd0, bus.wr_data}, {16'd0, exp[15:0]});
            end
        end
    end

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("start_in_ready", {31'd0, bus.in_ready}, 1);
        checkOutput("start_busy", {31'd0, busy}, 1);
        checkOutput("start_cpu_hold", {31'd0, cpu_hold}, 1);
        checkOutput("start_done", {31'd0, done}, 0);
        checkOutput("start_err", {31'd0, err}, 0);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps, input bit with_start);
        int waited;
        int idle;
        if (gaps) begin
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        start        = with_start;
        waited       = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        if (!bus.in_ready) checkOutput("in_ready_wait", {31'd0, bus.in_ready}, 1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(input bit gaps, input bit mid_start, input bit check_end);
        int n;
        int word;
        logic [7:0] hi;
        logic [7:0] csum;
        logic ok;
        n    = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
        word = 0;
        hi   = 8'd0;
        csum = 8'd0;
        for (int k = 0; k < stream.size(); k++) begin
            if (k >= 1 && k <= 2 * n) begin
                if (k % 2 == 1) begin
                    hi = stream[k];
                end else begin
                    sb.push_back({word[7:0], hi, stream[k]});
                    word++;
                end
            end
            if (k < stream.size() - 1) csum = csum + stream[k];
            sendByte(stream[k], gaps, mid_start && (k == 3));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (check_end) begin
            ok = (csum == stream[stream.size() - 1]);
            checkOutput("end_done", {31'd0, done}, {31'd0, ok});
            checkOutput("end_err", {31'd0, err}, {31'd0, !ok});
            checkOutput("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
            checkOutput("end_busy", {31'd0, busy}, 0);
            checkOutput("end_in_ready", {31'd0, bus.in_ready}, 0);
            checkOutput("sb_drained", sb.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] cs;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 0);
        checkOutput("rst_wr_en", {31'd0, bus.wr_en}, 0);
        checkOutput("rst_wr_addr", {24'd0, bus.wr_addr}, 0);
        checkOutput("rst_wr_data", {16'd0, bus.wr_data}, 0);
        checkOutput("rst_cpu_hold", {31'd0, cpu_hold}, 1);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_err", {31'd0, err}, 0);

        // Idle traffic without a start must be ignored.
        repeat (8) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 0);
        checkOutput("idle_cpu_hold", {31'd0, cpu_hold}, 1);

        $display("[TB] basic load");
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] bad checksum");
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] flow control with stray start");
        stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        pulseStart();
        applyStimulus(1'b1, 1'b1, 1'b1);

        $display("[TB] full 256-word image");
        stream = {};
        cs = 8'h00;
        stream.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(~8'(i));
            cs = cs + 8'(i) + ~8'(i);
        end
        stream.push_back(cs);
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        $display("[TB] reset mid-load");
        stream = '{8'h02, 8'h12, 8'h34};
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_wr_en", {31'd0, bus.wr_en}, 0);
        checkOutput("midrst_cpu_hold", {31'd0, cpu_hold}, 1);
        checkOutput("midrst_busy", {31'd0, busy}, 0);
        checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 0);
        checkOutput("midrst_sb", sb.size(), 0);

        stream = '{8'h01, 8'h55, 8'hAA, 8'h00};
        pulseStart();
        applyStimulus(1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("sb_empty_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time sequencer for the 256×16 instruction ROM. It accepts a byte stream over a valid/ready handshake and assembles byte pairs into 16-bit instructions. It writes them to consecutive instruction-memory addresses through the memory's write port, and holds the CPU until a complete, checksum-verified image is resident. It sits between the host/UART byte source and the instruction memory, alongside the PC.

## Interface
- `ADDR_W`, default 8: instruction address width (256 words).
- `DATA_W`, default 16: instruction width, fixed at two bytes.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to begin a load.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a byte.
- `wr_en` output 1: instruction-memory write strobe.
- `wr_addr` output ADDR_W: write address.
- `wr_data` output DATA_W: instruction word to write.
- `cpu_hold` output 1: keeps the PC/CPU stalled.
- `busy` output 1: load in progress.
- `done` output 1: last load succeeded (level).
- `err` output 1: last load failed its checksum (level).

## Operation
- Stream format:
  - Length byte L gives the word count N; L=0 means N=256.
  - Then 2N data bytes, high byte first.
  - Then one checksum byte, equal to the 8-bit modular sum of L and all data bytes.
- A byte is accepted on any edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: IDLE, LEN, HI, LO, CSUM, DONE, ERR.
- IDLE/DONE/ERR:
  - `start` moves the block to LEN.
  - On that edge `done`, `err`, the checksum accumulator, the word counter and `wr_addr` are cleared, and `cpu_hold` is set to 1.
- LEN: on accept, load the counter with N (9 bits), seed the sum with L, go to HI.
- HI: on accept, latch the high byte, add it to the sum, go to LO.
- LO: on accept:
  - Form `wr_data = {hi, in_data}` and add the byte to the sum.
  - Pulse `wr_en` for exactly one cycle on the following cycle, with `wr_addr` equal to the current word index.
  - Decrement the remaining count. Go to HI if words remain, else CSUM.
- The index increments after each write. It never exceeds 255; for N=256 the final write is at 0xFF and no wrap is issued.
- CSUM: on accept, compare with the sum.
  - Match: go to DONE, `done`=1, `cpu_hold`=0.
  - Mismatch: go to ERR, `err`=1, `cpu_hold` stays 1.
  - Already-written words are not rolled back.
- `start` while `busy` is ignored.
- Signal levels by state:
  - `in_ready` = 1 only in LEN/HI/LO/CSUM.
  - `busy` = 1 only in LEN/HI/LO/CSUM.
  - `wr_en` is never asserted outside the cycle after a LO accept.
- `rst` at any time, including mid-load, returns the block to IDLE. Any pending write pulse is dropped.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `cpu_hold`=1, `busy`=0, `done`=0, `err`=0.
- `in_ready` rises the cycle after `start` is sampled.
- Write latency: `wr_en`/`wr_addr`/`wr_data` are registered and valid in the cycle after the LO accept.
- `in_ready` stays high through that write cycle, so back-to-back bytes sustain one byte per clock. Minimum load time is 2N+2 accepted bytes plus 1 cycle.
- `done`/`err`/`cpu_hold` update in the cycle after the checksum accept. `busy` and `in_ready` fall in that same cycle.
- Every output is a register; there is no combinational path from inputs to outputs except `in_ready`, which depends on state only.

## Structure
- Shared package `imem_loader_pkg`:
  - `ADDR_W`/`DATA_W` constants and the `IMEM_DEPTH`=256 constant.
  - State enum `loader_state_t`.
  - These are also used by the instruction memory and the PC.
- No sub-module. Checksum accumulator, byte latch and word counter are inline in one FSM module.

## Test plan
- Reset only: all outputs at their reset values, including `cpu_hold`=1. `in_data` toggling with `in_valid`=1 produces no `wr_en`.
- Basic load:
  - `start`, then bytes 02,12,34,AB,CD,C0.
  - Required: writes 0x00←0x1234, then 0x01←0xABCD, one `wr_en` pulse each.
  - Then `done`=1, `err`=0, `cpu_hold`=0, `busy`=0.
- Bad checksum: same stream ending C1 gives both writes, then `err`=1, `done`=0, `cpu_hold`=1. A new `start` clears `err`.
- Flow control: same stream as the basic load with random `in_valid` gaps, plus `start` pulsed mid-load. Result is identical to the basic load, and the extra `start` has no effect.
- Full image: L=00, 512 data bytes (word i = {i, ~i}), correct checksum. Required: 256 writes covering addresses 0x00–0xFF in order, no write after 0xFF, `done`=1.
- Reset mid-load:
  - `rst` after bytes 02,12,34 gives IDLE, `wr_en`=0, `cpu_hold`=1, `busy`=0.
  - A subsequent clean load of 01,55,AA,00 writes 0x00←0x55AA and sets `done`=1.
